axi_round_complex_sched: RTL and testbench
==========================================

Name: axi_round_complex_sched

Overview:
Packet-level scheduler that shares one complex rounding datapath (2*WIDTH_IN -> 2*WIDTH_OUT, 1:1 beats, tlast preserved) between NUM_PORTS AXI-Stream requesters. Round-robin arbitration happens on packet boundaries. Each granted packet's source port is queued in a tag FIFO. Output beats returning from the datapath are steered back to the originating port. Sits between per-channel RFNoC stream sources and a single shared rounding instance.

Parameters:
NUM_PORTS, 4, number of requester/return port pairs (2..8)
IWIDTH, 48, complex input beat width (2*WIDTH_IN)
OWIDTH, 32, complex output beat width (2*WIDTH_OUT)
TAG_DEPTH_LOG2, 3, log2 of the in-flight packet tag FIFO depth

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
port_enable  in  NUM_PORTS  per-port arbitration enable
i_tdata  in  NUM_PORTS*IWIDTH  requester data, port k at [k*IWIDTH +: IWIDTH]
i_tlast  in  NUM_PORTS  requester end-of-packet
i_tvalid  in  NUM_PORTS  requester valid
i_tready  out  NUM_PORTS  requester ready
m_tdata  out  IWIDTH  to shared datapath input
m_tlast  out  1  to datapath
m_tvalid  out  1  to datapath
m_tready  in  1  from datapath
s_tdata  in  OWIDTH  from shared datapath output
s_tlast  in  1  from datapath
s_tvalid  in  1  from datapath
s_tready  out  1  to datapath
o_tdata  out  NUM_PORTS*OWIDTH  return data, port k at [k*OWIDTH +: OWIDTH]
o_tlast  out  NUM_PORTS  return end-of-packet
o_tvalid  out  NUM_PORTS  return valid
o_tready  in  NUM_PORTS  return ready
busy  out  1  packet granted or any tag outstanding

Behaviour:
- Reset (reset low, async): state IDLE, rr pointer 0, grant 0, tag FIFO empty. i_tready, m_tvalid, s_tready and o_tvalid are all 0; busy 0.
- FSM IDLE:
  - Candidates are ports with port_enable[k] & i_tvalid[k].
  - If any candidate exists and the tag FIFO is not full, grant the first candidate at or after the rr pointer (modular search).
  - In the same cycle, register grant and push the port index into the tag FIFO, then go to ACTIVE.
  - m_tvalid = 0 and all i_tready = 0 in IDLE, so the first beat reaches m_* one cycle after the request is seen.
- FSM ACTIVE:
  - m_* = i_*[grant] combinationally; i_tready[grant] = m_tready; all other i_tready = 0.
  - On a beat with m_tvalid & m_tready & m_tlast: rr pointer = (grant+1) mod NUM_PORTS, go to IDLE.
  - Back-to-back packets therefore have one idle cycle between them.
- port_enable deasserted mid-packet: the current packet completes. Port k is excluded from the next arbitration only.
- Return path:
  - Head tag h valid (FIFO not empty): o_tdata[h], o_tlast[h] = s_*; o_tvalid[h] = s_tvalid; s_tready = o_tready[h]. Other o_tvalid = 0.
  - On s_tvalid & s_tready & s_tlast, pop the head.
  - FIFO empty: s_tready = 0 and all o_tvalid = 0. A stray datapath beat stalls; it is never dropped or misrouted.
  - o_tdata lanes of non-selected ports may carry s_tdata; only o_tvalid qualifies them.
- Tag FIFO:
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Full blocks new grants only. An ACTIVE packet continues.
- busy = (state==ACTIVE) | FIFO not empty.
- Datapath contract: strictly 1 output beat per input beat, packet order preserved, any latency. Packet count in flight is bounded by 2^TAG_DEPTH_LOG2.

Test Plan:
- Single port 0, 3-beat packet, datapath latency 2, all readys high -> m_tvalid rises 1 cycle after i_tvalid[0]; o_tvalid[0] carries 3 beats, last with o_tlast[0]; busy falls after the final pop.
- Ports 0..3 each holding two 2-beat packets continuously -> grant order 0,1,2,3,0,1,2,3; each o port receives exactly its own 4 beats in order.
- port_enable = 4'b1011 with all ports requesting -> port 2 is never granted. Clearing port_enable[1] mid-packet on port 1 -> that packet completes, then port 1 is skipped.
- Datapath output held off (s_tready path blocked via o_tready = 0) for 8 single-beat packets with TAG_DEPTH_LOG2 = 3 -> 8 grants, then no ninth grant until one pop. Simultaneous push/pop keeps the count at 8.
- o_tready[1] = 0 while the head tag is 1 -> s_tready = 0 and the port 0 return stalls behind it (in-order). Raising o_tready[1] resumes delivery with no loss.
- Assert reset mid-packet in ACTIVE with 2 tags outstanding -> all valids/readys 0 immediately, FIFO empty, pointer 0. After release, a port 3 request is granted normally.

Source files
------------

// File: rtl/axi_round_complex_sched.sv
// Packet-level round-robin scheduler sharing one complex rounding datapath between
// NUM_PORTS AXI-Stream requesters; a tag FIFO steers returning beats to their source port.
module axi_round_complex_sched #(
    parameter int NUM_PORTS      = 4,
    parameter int IWIDTH         = 48,
    parameter int OWIDTH         = 32,
    parameter int TAG_DEPTH_LOG2 = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          port_enable,
    input  logic [NUM_PORTS*IWIDTH-1:0]   i_tdata,
    input  logic [NUM_PORTS-1:0]          i_tlast,
    input  logic [NUM_PORTS-1:0]          i_tvalid,
    output logic [NUM_PORTS-1:0]          i_tready,
    output logic [IWIDTH-1:0]             m_tdata,
    output logic                          m_tlast,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    input  logic [OWIDTH-1:0]             s_tdata,
    input  logic                          s_tlast,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    output logic [NUM_PORTS*OWIDTH-1:0]   o_tdata,
    output logic [NUM_PORTS-1:0]          o_tlast,
    output logic [NUM_PORTS-1:0]          o_tvalid,
    input  logic [NUM_PORTS-1:0]          o_tready,
    output logic                          busy
);

    localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int DEPTH = 1 << TAG_DEPTH_LOG2;
    localparam logic [TAG_DEPTH_LOG2:0] FULL_CNT = (TAG_DEPTH_LOG2+1)'(DEPTH);
    localparam logic [PW-1:0]           LAST_PORT = PW'(NUM_PORTS - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                    state_r;
    state_t                    state_next_s;
    logic [PW-1:0]             rr_ptr_r;
    logic [PW-1:0]             grant_r;
    logic [PW-1:0]             pick_s;
    logic                      pick_valid_s;
    logic [NUM_PORTS-1:0]      cand_s;
    logic [PW-1:0]             tag_mem_r [DEPTH];
    logic [TAG_DEPTH_LOG2-1:0] wr_ptr_r;
    logic [TAG_DEPTH_LOG2-1:0] rd_ptr_r;
    logic [TAG_DEPTH_LOG2:0]   count_r;
    logic                      fifo_full_s;
    logic                      fifo_empty_s;
    logic                      push_s;
    logic                      pop_s;
    logic                      m_last_fire_s;
    logic [PW-1:0]             head_s;

    assign cand_s        = port_enable & i_tvalid;
    assign fifo_full_s   = (count_r == FULL_CNT);
    assign fifo_empty_s  = (count_r == {(TAG_DEPTH_LOG2+1){1'b0}});
    assign push_s        = (state_r == ST_IDLE) & pick_valid_s & ~fifo_full_s;
    assign m_last_fire_s = (state_r == ST_ACTIVE) & m_tvalid & m_tready & m_tlast;
    assign pop_s         = ~fifo_empty_s & s_tvalid & s_tready & s_tlast;
    assign head_s        = tag_mem_r[rd_ptr_r];
    assign busy          = (state_r == ST_ACTIVE) | ~fifo_empty_s;

    // Round-robin pick: first candidate at or after the pointer, wrapping modulo NUM_PORTS
    always_comb begin
        pick_valid_s = 1'b0;
        pick_s       = rr_ptr_r;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!pick_valid_s && cand_s[(int'(rr_ptr_r) + i) % NUM_PORTS]) begin
                pick_valid_s = 1'b1;
                pick_s       = PW'((int'(rr_ptr_r) + i) % NUM_PORTS);
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: a grant opens a packet, its last accepted beat closes it
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:   state_next_s = push_s ? ST_ACTIVE : ST_IDLE;
            ST_ACTIVE: state_next_s = m_last_fire_s ? ST_IDLE : ST_ACTIVE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: the granted requester is wired straight through to the datapath
    always_comb begin
        m_tdata  = i_tdata[grant_r*IWIDTH +: IWIDTH];
        m_tlast  = i_tlast[grant_r];
        m_tvalid = 1'b0;
        i_tready = {NUM_PORTS{1'b0}};
        case (state_r)
            ST_ACTIVE: begin
                m_tvalid          = i_tvalid[grant_r];
                i_tready[grant_r] = m_tready;
            end
            ST_IDLE: begin
                m_tvalid = 1'b0;
            end
            default: begin
                m_tvalid = 1'b0;
            end
        endcase
    end

    // Grant and round-robin pointer; pointer moves past the grant once its packet ends
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_r  <= {PW{1'b0}};
            rr_ptr_r <= {PW{1'b0}};
        end else if (push_s) begin
            grant_r  <= pick_s;
            rr_ptr_r <= rr_ptr_r;
        end else if (m_last_fire_s) begin
            grant_r  <= grant_r;
            rr_ptr_r <= (grant_r == LAST_PORT) ? {PW{1'b0}} : grant_r + PW'(1);
        end else begin
            grant_r  <= grant_r;
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Tag FIFO: simultaneous push and pop leave the occupancy unchanged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {TAG_DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {TAG_DEPTH_LOG2{1'b0}};
            count_r  <= {(TAG_DEPTH_LOG2+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem_r[i] <= {PW{1'b0}};
            end
        end else begin
            if (push_s) begin
                tag_mem_r[wr_ptr_r] <= pick_s;
                wr_ptr_r            <= wr_ptr_r + TAG_DEPTH_LOG2'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + TAG_DEPTH_LOG2'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (TAG_DEPTH_LOG2+1)'(1);
                2'b01:   count_r <= count_r - (TAG_DEPTH_LOG2+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Return steering: only the head-tag port sees valid; with no tag the datapath stalls
    always_comb begin
        o_tdata  = {NUM_PORTS{s_tdata}};
        o_tvalid = {NUM_PORTS{1'b0}};
        o_tlast  = {NUM_PORTS{1'b0}};
        s_tready = 1'b0;
        if (!fifo_empty_s) begin
            o_tvalid[head_s] = s_tvalid;
            o_tlast[head_s]  = s_tlast;
            s_tready         = o_tready[head_s];
        end else begin
            s_tready = 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_round_complex_sched.sv
// Scoreboard bench: per-port packet sources, a fixed-latency datapath model and
// per-port expected-return queues filled at stimulus time.
module tb_axi_round_complex_sched;

    localparam int NP  = 4;
    localparam int IW  = 48;
    localparam int OW  = 32;
    localparam int TD  = 3;
    localparam int LAT = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NP-1:0]     port_enable = '1;
    logic [NP*IW-1:0]  i_tdata = '0;
    logic [NP-1:0]     i_tlast = '0;
    logic [NP-1:0]     i_tvalid = '0;
    logic [NP-1:0]     i_tready;
    logic [IW-1:0]     m_tdata;
    logic              m_tlast;
    logic              m_tvalid;
    logic              m_tready = 1'b1;
    logic [OW-1:0]     s_tdata = '0;
    logic              s_tlast = 1'b0;
    logic              s_tvalid = 1'b0;
    logic              s_tready;
    logic [NP*OW-1:0]  o_tdata;
    logic [NP-1:0]     o_tlast;
    logic [NP-1:0]     o_tvalid;
    logic [NP-1:0]     o_tready = '1;
    logic              busy;

    always #5 clk = ~clk;

    axi_round_complex_sched #(
        .NUM_PORTS(NP), .IWIDTH(IW), .OWIDTH(OW), .TAG_DEPTH_LOG2(TD)
    ) dut (
        .clk(clk), .reset(reset), .port_enable(port_enable),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .busy(busy)
    );

    typedef struct packed {
        int            avail;
        logic          last;
        logic [OW-1:0] data;
    } dp_beat_t;

    logic [IW:0]   src_q [NP][$];
    logic [OW:0]   exp_q [NP][$];
    dp_beat_t      dp_q[$];
    int            grant_log[$];
    int            recv_cnt [NP];
    int            pops;
    logic [NP-1:0] in_pkt;
    int            cyc;
    int            seq;
    int            vectors;
    int            miscompares;

    // Stand-in for the rounding datapath: any fixed function of the whole beat
    function automatic logic [OW-1:0] dp_fn(input logic [IW-1:0] x);
        return x[47:16] ^ {x[15:0], x[15:0]};
    endfunction

    function automatic bit drained();
        bit e;
        e = (dp_q.size() == 0);
        for (int k = 0; k < NP; k++) begin
            if (src_q[k].size() != 0 || exp_q[k].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic add_pkt(input int k, input int n);
        logic [IW-1:0] d;
        for (int b = 0; b < n; b++) begin
            d = {8'(k), 8'(seq), 32'($urandom)};
            seq++;
            src_q[k].push_back({(b == n - 1), d});
            exp_q[k].push_back({(b == n - 1), dp_fn(d)});
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NP; k++) begin
            if (src_q[k].size() != 0) begin
                i_tvalid[k]         = 1'b1;
                i_tlast[k]          = src_q[k][0][IW];
                i_tdata[k*IW +: IW] = src_q[k][0][IW-1:0];
            end else begin
                i_tvalid[k]         = 1'b0;
                i_tlast[k]          = 1'b0;
                i_tdata[k*IW +: IW] = '0;
            end
        end
        if (dp_q.size() != 0 && dp_q[0].avail <= cyc) begin
            s_tvalid = 1'b1;
            s_tlast  = dp_q[0].last;
            s_tdata  = dp_q[0].data;
        end else begin
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            s_tdata  = '0;
        end
    endtask

    // One clock: sample handshakes mid-cycle, update models after the edge, redrive
    task automatic cycle();
        logic [NP-1:0]    in_f, o_f, o_v, o_l;
        logic [NP*OW-1:0] o_d;
        logic [IW-1:0]    md;
        logic             ml, m_f, s_f;
        logic [IW:0]      sbeat;
        logic [OW:0]      ebeat;
        dp_beat_t         dbeat;
        @(negedge clk);
        in_f = i_tvalid & i_tready;
        m_f  = m_tvalid & m_tready;
        s_f  = s_tvalid & s_tready;
        o_v  = o_tvalid;
        o_f  = o_tvalid & o_tready;
        o_d  = o_tdata;
        o_l  = o_tlast;
        md   = m_tdata;
        ml   = m_tlast;
        if (o_v != '0) begin
            vectors++;
            if ($countones(o_v) > 1) begin
                miscompares++;
                $display("FAIL onehot_o_tvalid: got %b required at most one bit", o_v);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NP; k++) begin
            if (in_f[k] && src_q[k].size() != 0) begin
                sbeat = src_q[k].pop_front();
                if (!in_pkt[k]) grant_log.push_back(k);
                in_pkt[k] = ~sbeat[IW];
            end
        end
        if (m_f) begin
            dbeat.avail = cyc + LAT - 1;
            dbeat.last  = ml;
            dbeat.data  = dp_fn(md);
            dp_q.push_back(dbeat);
        end
        if (s_f && dp_q.size() != 0) begin
            dbeat = dp_q.pop_front();
        end
        for (int k = 0; k < NP; k++) begin
            if (o_f[k]) begin
                vectors++;
                if (exp_q[k].size() == 0) begin
                    miscompares++;
                    $display("FAIL return_port%0d: got unexpected beat %h required none", k, o_d[k*OW +: OW]);
                end else begin
                    ebeat = exp_q[k].pop_front();
                    if ({o_l[k], o_d[k*OW +: OW]} !== ebeat) begin
                        miscompares++;
                        $display("FAIL return_port%0d: got %h required %h", k, {o_l[k], o_d[k*OW +: OW]}, ebeat);
                    end
                end
                recv_cnt[k]++;
                if (o_l[k]) pops++;
            end
        end
        drive();
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic run_until_drained(input int budget, input string name);
        int n = 0;
        while (!drained() && n < budget) begin
            cycle();
            n++;
        end
        vectors++;
        if (!drained()) begin
            miscompares++;
            $display("FAIL %s_drain: got timeout after %0d cycles required all beats returned", name, budget);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int k = 0; k < NP; k++) begin
            src_q[k].delete();
            exp_q[k].delete();
            recv_cnt[k] = 0;
        end
        dp_q.delete();
        grant_log.delete();
        in_pkt      = '0;
        pops        = 0;
        port_enable = '1;
        o_tready    = '1;
        m_tready    = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({i_tready, m_tvalid, s_tready, o_tvalid, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_idle: got %b required 0", {i_tready, m_tvalid, s_tready, o_tvalid, busy});
        end
        for (int k = 0; k < NP; k++) add_pkt(k, 2);
        run(2);
        vectors++;
        if (busy !== 1'b1 || i_tready !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_pre_active: got busy=%b i_tready=%b required 1 0001", busy, i_tready);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({i_tready, m_tvalid, s_tready, o_tvalid, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_async: got %b required 0", {i_tready, m_tvalid, s_tready, o_tvalid, busy});
        end
    endtask

    task automatic test_single();
        logic [IW-1:0] first;
        do_reset();
        add_pkt(0, 3);
        first = src_q[0][0][IW-1:0];
        cycle();
        vectors++;
        if (i_tvalid[0] !== 1'b1 || m_tvalid !== 1'b0 || i_tready !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_first_cycle: got m_tvalid=%b i_tready=%b required 0 0000", m_tvalid, i_tready);
        end
        cycle();
        vectors++;
        if (m_tvalid !== 1'b1 || m_tdata !== first || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_m_rise: got v=%b d=%h busy=%b required 1 %h 1", m_tvalid, m_tdata, busy, first);
        end
        run_until_drained(100, "single");
        vectors++;
        if (recv_cnt[0] !== 3 || pops !== 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done: got beats=%0d pops=%0d busy=%b required 3 1 0", recv_cnt[0], pops, busy);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < NP; k++) add_pkt(k, 2);
        end
        run_until_drained(300, "rr");
        vectors++;
        if (grant_log.size() !== 8) begin
            miscompares++;
            $display("FAIL rr_grant_count: got %0d required 8", grant_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (grant_log[i] !== i % NP) begin
                    miscompares++;
                    $display("FAIL rr_order_%0d: got %0d required %0d", i, grant_log[i], i % NP);
                end
            end
        end
        for (int k = 0; k < NP; k++) begin
            vectors++;
            if (recv_cnt[k] !== 4) begin
                miscompares++;
                $display("FAIL rr_beats_port%0d: got %0d required 4", k, recv_cnt[k]);
            end
        end
    endtask

    task automatic test_port_enable();
        int n2 = 0;
        int n = 0;
        do_reset();
        port_enable = 4'b1011;
        for (int k = 0; k < NP; k++) begin
            add_pkt(k, 1);
            add_pkt(k, 1);
        end
        run(40);
        foreach (grant_log[i]) if (grant_log[i] == 2) n2++;
        vectors++;
        if (n2 !== 0 || grant_log.size() !== 6 || recv_cnt[2] !== 0) begin
            miscompares++;
            $display("FAIL pe_mask: got port2 grants=%0d total=%0d required 0 6", n2, grant_log.size());
        end
        port_enable = '1;
        run_until_drained(200, "pe_mask");

        do_reset();
        add_pkt(1, 4);
        add_pkt(1, 1);
        while (grant_log.size() == 0 && n < 20) begin
            cycle();
            n++;
        end
        port_enable = 4'b1101;
        add_pkt(0, 1);
        add_pkt(2, 1);
        run(40);
        vectors++;
        if (grant_log.size() !== 3 || recv_cnt[1] !== 4) begin
            miscompares++;
            $display("FAIL pe_mid_count: got grants=%0d port1 beats=%0d required 3 4", grant_log.size(), recv_cnt[1]);
        end else begin
            vectors++;
            if (grant_log[0] !== 1 || grant_log[1] !== 2 || grant_log[2] !== 0) begin
                miscompares++;
                $display("FAIL pe_mid_order: got %0d,%0d,%0d required 1,2,0", grant_log[0], grant_log[1], grant_log[2]);
            end
        end
        port_enable = '1;
        run_until_drained(200, "pe_mid");
    endtask

    task automatic test_tag_full();
        do_reset();
        o_tready = '0;
        for (int i = 0; i < 12; i++) add_pkt(0, 1);
        run(40);
        vectors++;
        if (grant_log.size() !== 8 || i_tready !== 4'b0000 || m_tvalid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL full_block: got grants=%0d i_tready=%b m_tvalid=%b required 8 0000 0", grant_log.size(), i_tready, m_tvalid);
        end
        o_tready = '1;
        run(3);
        o_tready = '0;
        run(30);
        vectors++;
        if (pops !== 3 || grant_log.size() !== 11) begin
            miscompares++;
            $display("FAIL full_pushpop: got pops=%0d grants=%0d required 3 11", pops, grant_log.size());
        end
        o_tready = '1;
        run_until_drained(200, "full");
    endtask

    task automatic test_inorder_stall();
        do_reset();
        o_tready = 4'b1101;
        add_pkt(1, 2);
        run(3);
        add_pkt(0, 1);
        run(20);
        vectors++;
        if (s_tready !== 1'b0 || o_tvalid !== 4'b0010 || recv_cnt[0] !== 0 || recv_cnt[1] !== 0) begin
            miscompares++;
            $display("FAIL stall_hold: got s_tready=%b o_tvalid=%b r0=%0d required 0 0010 0", s_tready, o_tvalid, recv_cnt[0]);
        end
        o_tready = '1;
        run_until_drained(100, "stall");
        vectors++;
        if (recv_cnt[1] !== 2 || recv_cnt[0] !== 1) begin
            miscompares++;
            $display("FAIL stall_resume: got r1=%0d r0=%0d required 2 1", recv_cnt[1], recv_cnt[0]);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        o_tready = '0;
        add_pkt(2, 1);
        add_pkt(3, 4);
        while (!(grant_log.size() == 2 && in_pkt[3]) && n < 40) begin
            cycle();
            n++;
        end
        vectors++;
        if (m_tvalid !== 1'b1 || busy !== 1'b1 || grant_log.size() !== 2) begin
            miscompares++;
            $display("FAIL rstmid_setup: got m_tvalid=%b grants=%0d required 1 2", m_tvalid, grant_log.size());
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({i_tready, m_tvalid, s_tready, o_tvalid, busy} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_zero: got %b required 0", {i_tready, m_tvalid, s_tready, o_tvalid, busy});
        end
        do_reset();
        add_pkt(3, 1);
        add_pkt(1, 1);
        run_until_drained(100, "rstmid");
        vectors++;
        if (grant_log.size() !== 2 || grant_log[0] !== 1 || grant_log[1] !== 3) begin
            miscompares++;
            $display("FAIL rstmid_regrant: got %0d grants first=%0d required 2 grants 1 then 3",
                     grant_log.size(), (grant_log.size() != 0) ? grant_log[0] : -1);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        seq         = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_port_enable();
        test_tag_full();
        test_inorder_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
